// File: rtl/trace_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
//   Shared definitions for the trace capture front end.
//   Contents:
//     tf_state_e      capture FSM encoding (IDLE / ARMED / CAPTURE)
//     TfEofBits       width of the end-of-frame flag stored with each sample
//     tf_entry_bits() buffer entry width for a given sample width ({eof, data})
// -----------------------------------------------------------------------------
package trace_pkg;

   typedef enum logic [1:0] {
      TF_IDLE    = 2'd0,
      TF_ARMED   = 2'd1,
      TF_CAPTURE = 2'd2
   } tf_state_e;

   localparam int unsigned TfEofBits = 1;

   // Each buffered entry carries the sample plus its eof flag in the MSB.
   function automatic int unsigned tf_entry_bits(input int unsigned data_bits);
      return data_bits + TfEofBits;
   endfunction

endpackage : trace_pkg

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with first-word fall-through output. The head entry is
//   presented combinationally while the FIFO is non-empty, so a write becomes
//   visible on the output one cycle after it is accepted.
// Parameters:
//   Width  entry width in bits
//   Depth  number of entries (power of 2, >= 4)
// Ports:
//   clk_i      clock
//   rst_i      synchronous reset, active-low; empties the FIFO
//   wr_en_i    write request, ignored while full
//   wr_data_i  write data
//   rd_en_i    read request (pop head), ignored while empty
//   rd_data_o  head entry; all zeros while empty
//   full_o     no free entry
//   empty_o    no valid entry
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int Width = 9,
   parameter int Depth = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wr_en_i,
   input  logic [Width-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [Width-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AddrBits = $clog2(Depth);

   logic [Width-1:0]  mem_q [Depth];
   // One extra pointer bit distinguishes full from empty when addresses match.
   logic [AddrBits:0] wr_ptr_q, wr_ptr_d;
   logic [AddrBits:0] rd_ptr_q, rd_ptr_d;
   logic              do_wr;
   logic              do_rd;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AddrBits] != rd_ptr_q[AddrBits]) &&
                    (wr_ptr_q[AddrBits-1:0] == rd_ptr_q[AddrBits-1:0]);

   assign do_wr = wr_en_i && !full_o;
   assign do_rd = rd_en_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is not reset; the output is masked while empty instead.
   always_ff @(posedge clk_i) begin
      if (do_wr) mem_q[wr_ptr_q[AddrBits-1:0]] <= wr_data_i;
   end

   assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AddrBits-1:0]];

endmodule : sync_fifo

// File: rtl/trace_framer.sv
// -----------------------------------------------------------------------------
// trace_framer
//   Capture stage in front of the stream-to-memory DMA writer. Waits for an
//   armed trigger on a free-running sample stream, captures exactly one frame
//   of cfg_frame_len samples into a buffer and streams it out (valid/ready)
//   with eof on the last sample. The sample input cannot be stalled: frame
//   samples arriving while the buffer is full are dropped and counted, and do
//   not count toward the frame length.
// Configuration macro:
//   TRACE_FRAMER_AUTOREARM_EN  defined: after the eof write the FSM re-arms
//                              with the latched length (status not cleared);
//                              undefined: after the eof write it returns to IDLE.
// Handshake (dout_*): a beat transfers on a rising edge where dout_valid and
//   dout_ready are both 1; while dout_valid=1 and dout_ready=0, dout_data and
//   dout_eof hold steady; dout_valid never depends on dout_ready.
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   smp_valid, smp_data   sample strobe and value (no back-pressure)
//   trig                  trigger, qualified by smp_valid
//   cfg_arm               pulse: arm for one frame (ignored unless IDLE)
//   cfg_frame_len         samples per frame, latched on an accepted arm
//   dout_valid/ready/data/eof  output stream to the DMA
//   sts_busy              FSM not IDLE
//   sts_done              pulse after the eof sample is written to the buffer
//   sts_overflow          sticky: a sample was dropped since last accepted arm
//   sts_drop_cnt          dropped samples since last accepted arm, saturating
//   dbg_state             current FSM state (tf_state_e encoding)
// -----------------------------------------------------------------------------
module trace_framer
   import trace_pkg::*;
#(
   parameter int StrmDataBits = 8,
   parameter int LengthBits   = 16,
   parameter int FifoDepth    = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    smp_valid,
   input  logic [StrmDataBits-1:0] smp_data,
   input  logic                    trig,
   input  logic                    cfg_arm,
   input  logic [LengthBits-1:0]   cfg_frame_len,
   output logic                    dout_valid,
   input  logic                    dout_ready,
   output logic [StrmDataBits-1:0] dout_data,
   output logic                    dout_eof,
   output logic                    sts_busy,
   output logic                    sts_done,
   output logic                    sts_overflow,
   output logic [LengthBits-1:0]   sts_drop_cnt,
   output logic [1:0]              dbg_state
);

   localparam int EntryBits = int'(tf_entry_bits(StrmDataBits));

   tf_state_e             state_q, state_d;
   logic [LengthBits-1:0] len_q, len_d;
   logic [LengthBits-1:0] rem_q, rem_d;
   logic                  ovf_q, ovf_d;
   logic [LengthBits-1:0] drop_q, drop_d;
   logic                  done_q, done_d;

   logic                  take;      // current sample belongs to the frame
   logic                  is_last;   // a write now would complete the frame
   logic                  wr_en;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [EntryBits-1:0]  fifo_rd_data;

   assign is_last = (rem_q == LengthBits'(1));

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      rem_d   = rem_q;
      ovf_d   = ovf_q;
      drop_d  = drop_q;
      done_d  = 1'b0;
      take    = 1'b0;
      wr_en   = 1'b0;

      unique case (state_q)
         TF_IDLE: begin
            // A trigger in the arming cycle is not seen: IDLE never takes samples.
            if (cfg_arm && (cfg_frame_len != '0)) begin
               state_d = TF_ARMED;
               len_d   = cfg_frame_len;
               rem_d   = cfg_frame_len;
               ovf_d   = 1'b0;
               drop_d  = '0;
            end
         end
         TF_ARMED: begin
            if (smp_valid && trig) begin
               state_d = TF_CAPTURE;
               take    = 1'b1;
            end
         end
         TF_CAPTURE: begin
            take = smp_valid;
         end
         default: state_d = TF_IDLE;
      endcase

      if (take) begin
         if (fifo_full) begin
            // Dropped: the frame still needs the same number of samples.
            ovf_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + LengthBits'(1);
         end else begin
            wr_en = 1'b1;
            rem_d = rem_q - LengthBits'(1);
            if (is_last) begin
               done_d = 1'b1;
               rem_d  = len_q;
`ifdef TRACE_FRAMER_AUTOREARM_EN
               state_d = TF_ARMED;
`else
               state_d = TF_IDLE;
`endif
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= TF_IDLE;
         len_q   <= '0;
         rem_q   <= '0;
         ovf_q   <= 1'b0;
         drop_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         rem_q   <= rem_d;
         ovf_q   <= ovf_d;
         drop_q  <= drop_d;
         done_q  <= done_d;
      end
   end

   sync_fifo #(
      .Width (EntryBits),
      .Depth (FifoDepth)
   ) u_fifo (
      .clk_i     (clk),
      .rst_i     (rst),
      .wr_en_i   (wr_en),
      .wr_data_i ({is_last, smp_data}),
      .rd_en_i   (dout_ready),
      .rd_data_o (fifo_rd_data),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign dout_valid   = !fifo_empty;
   assign dout_eof     = fifo_rd_data[EntryBits-1];
   assign dout_data    = fifo_rd_data[StrmDataBits-1:0];
   assign sts_busy     = (state_q != TF_IDLE);
   assign sts_done     = done_q;
   assign sts_overflow = ovf_q;
   assign sts_drop_cnt = drop_q;
   assign dbg_state    = state_q;

endmodule : trace_framer

// File: tb/tb_trace_framer.sv
// -----------------------------------------------------------------------------
// tb_trace_framer
//   Self-checking bench for trace_framer (FifoDepth=4). Expected output beats
//   ({eof, data}) are queued as stimulus is driven and compared by a monitor
//   when the DUT hands a beat over. Build with TRACE_FRAMER_AUTOREARM_EN to
//   exercise the re-arm variant.
// -----------------------------------------------------------------------------
module tb_trace_framer;

   localparam int DW = 8;
   localparam int LW = 16;
   localparam int FD = 4;
`ifdef TRACE_FRAMER_AUTOREARM_EN
   localparam logic AUTO = 1'b1;
`else
   localparam logic AUTO = 1'b0;
`endif
   localparam logic [1:0] ST_IDLE = 2'd0, ST_ARMED = 2'd1, ST_CAPT = 2'd2;

   logic          clk;
   logic          rst;
   logic          smp_valid;
   logic [DW-1:0] smp_data;
   logic          trig;
   logic          cfg_arm;
   logic [LW-1:0] cfg_frame_len;
   logic          dout_valid;
   logic          dout_ready;
   logic [DW-1:0] dout_data;
   logic          dout_eof;
   logic          sts_busy;
   logic          sts_done;
   logic          sts_overflow;
   logic [LW-1:0] sts_drop_cnt;
   logic [1:0]    dbg_state;

   int            n_checks = 0;
   int            n_errors = 0;
   int            done_cnt = 0;
   logic [DW:0]   exp_q[$];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   trace_framer #(
      .StrmDataBits (DW),
      .LengthBits   (LW),
      .FifoDepth    (FD)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .smp_valid     (smp_valid),
      .smp_data      (smp_data),
      .trig          (trig),
      .cfg_arm       (cfg_arm),
      .cfg_frame_len (cfg_frame_len),
      .dout_valid    (dout_valid),
      .dout_ready    (dout_ready),
      .dout_data     (dout_data),
      .dout_eof      (dout_eof),
      .sts_busy      (sts_busy),
      .sts_done      (sts_done),
      .sts_overflow  (sts_overflow),
      .sts_drop_cnt  (sts_drop_cnt),
      .dbg_state     (dbg_state)
   );

   // ---------------- checker ----------------
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic        prev_stall = 1'b0;
   logic [DW:0] prev_beat  = '0;

   always @(negedge clk) begin
      if (sts_done) done_cnt++;
      if (prev_stall && rst) begin
         check_eq("hold_valid", dout_valid, 1);
         check_eq("hold_beat", {dout_eof, dout_data}, prev_beat);
      end
      prev_stall = rst && dout_valid && !dout_ready;
      prev_beat  = {dout_eof, dout_data};
      if (rst && dout_valid && dout_ready) begin
         if (exp_q.size() == 0) check_eq("beat_unexpected", exp_q.size(), 1);
         else                   check_eq("beat", {dout_eof, dout_data}, exp_q.pop_front());
      end
   end

   // ---------------- drivers ----------------
   task automatic cyc(input logic v, input logic [DW-1:0] d, input logic t,
                      input logic a, input logic [LW-1:0] len);
      smp_valid     = v;
      smp_data      = d;
      trig          = t;
      cfg_arm       = a;
      cfg_frame_len = len;
      @(posedge clk);
      #1;
      smp_valid = 1'b0;
      trig      = 1'b0;
      cfg_arm   = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, '0);
   endtask

   task automatic arm(input logic [LW-1:0] len);
      cyc(1'b0, '0, 1'b0, 1'b1, len);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic push(input logic e, input logic [DW-1:0] d);
      exp_q.push_back({e, d});
   endtask

   task automatic drain(input int max_cycles);
      int k = 0;
      while (exp_q.size() != 0 && k < max_cycles) begin
         @(posedge clk);
         #1;
         k++;
      end
      check_eq("drain_left", exp_q.size(), 0);
      idle(1);
      check_eq("drain_valid", dout_valid, 0);
   endtask

   task automatic check_all_zero();
      check_eq("rst_valid", dout_valid, 0);
      check_eq("rst_data", dout_data, 0);
      check_eq("rst_eof", dout_eof, 0);
      check_eq("rst_busy", sts_busy, 0);
      check_eq("rst_done", sts_done, 0);
      check_eq("rst_ovf", sts_overflow, 0);
      check_eq("rst_drop", sts_drop_cnt, 0);
      check_eq("rst_state", dbg_state, ST_IDLE);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int          d0;
      logic [DW-1:0] d;
      rst = 1'b0; smp_valid = 1'b0; smp_data = '0; trig = 1'b0;
      cfg_arm = 1'b0; cfg_frame_len = '0; dout_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero();
      rst = 1'b1;
      idle(2);

      // 1: len=4, trigger on 0x13
      d0 = done_cnt;
      arm(16'd4);
      check_eq("t1_busy_armed", sts_busy, 1);
      check_eq("t1_state_armed", dbg_state, ST_ARMED);
      for (int i = 0; i < 16; i++) begin
         d = 8'h10 + 8'(i);
         if (d == 8'h13) check_eq("t1_no_early_valid", dout_valid, 0);
         if (d >= 8'h13 && d <= 8'h16) push(d == 8'h16, d);
         cyc(1'b1, d, d == 8'h13, 1'b0, '0);
      end
      drain(20);
      check_eq("t1_done_cnt", done_cnt - d0, 1);
      check_eq("t1_busy_end", sts_busy, AUTO);
      check_eq("t1_drop", sts_drop_cnt, 0);

      // 2: len=1, single beat
`ifdef TRACE_FRAMER_AUTOREARM_EN
      do_reset();
`endif
      d0 = done_cnt;
      arm(16'd1);
      for (int i = 0; i < 8; i++) begin
         d = 8'hA0 + 8'(i);
         if (d == 8'hA5) push(1'b1, d);
         cyc(1'b1, d, d == 8'hA5, 1'b0, '0);
      end
      drain(20);
      check_eq("t2_done_cnt", done_cnt - d0, 1);
      check_eq("t2_drop", sts_drop_cnt, 0);
      check_eq("t2_busy_end", sts_busy, AUTO);

      // 3: overflow with a 4-deep buffer, len=8
`ifdef TRACE_FRAMER_AUTOREARM_EN
      do_reset();
`endif
      d0 = done_cnt;
      dout_ready = 1'b0;
      arm(16'd8);
      for (int i = 0; i < 8; i++) begin
         d = 8'h30 + 8'(i);
         if (i < 4) push(1'b0, d);
         cyc(1'b1, d, i == 0, 1'b0, '0);
      end
      check_eq("t3_ovf", sts_overflow, 1);
      check_eq("t3_drop_mid", sts_drop_cnt, 4);
      check_eq("t3_busy_mid", sts_busy, 1);
      check_eq("t3_head_valid", dout_valid, 1);
      check_eq("t3_head_data", dout_data, 8'h30);
      dout_ready = 1'b1;
      idle(6);
      for (int i = 0; i < 4; i++) begin
         d = 8'h38 + 8'(i);
         push(i == 3, d);
         cyc(1'b1, d, 1'b0, 1'b0, '0);
      end
      check_eq("t3_busy_end", sts_busy, AUTO);
      check_eq("t3_drop_end", sts_drop_cnt, 4);
      drain(20);
      check_eq("t3_done_cnt", done_cnt - d0, 1);
      check_eq("t3_ovf_end", sts_overflow, 1);

      // 4: ignored arm/trigger cases
`ifdef TRACE_FRAMER_AUTOREARM_EN
      do_reset();
`endif
      d0 = done_cnt;
      arm(16'd0);
      check_eq("t4_len0_busy", sts_busy, 0);
      check_eq("t4_len0_ovf", sts_overflow, AUTO ? 0 : 1);
      check_eq("t4_len0_drop", sts_drop_cnt, AUTO ? 0 : 4);
      cyc(1'b1, 8'h50, 1'b1, 1'b1, 16'd3);
      check_eq("t4_arm_busy", sts_busy, 1);
      check_eq("t4_arm_state", dbg_state, ST_ARMED);
      check_eq("t4_arm_ovf_clr", sts_overflow, 0);
      check_eq("t4_arm_drop_clr", sts_drop_cnt, 0);
      cyc(1'b0, 8'h51, 1'b1, 1'b0, '0);
      cyc(1'b1, 8'h52, 1'b0, 1'b0, '0);
      check_eq("t4_no_capture", dout_valid, 0);
      check_eq("t4_still_armed", dbg_state, ST_ARMED);
      push(1'b0, 8'h53);
      cyc(1'b1, 8'h53, 1'b1, 1'b0, '0);
      check_eq("t4_capture", dbg_state, ST_CAPT);
      push(1'b0, 8'h54);
      cyc(1'b1, 8'h54, 1'b1, 1'b1, 16'd5);
      push(1'b1, 8'h55);
      cyc(1'b1, 8'h55, 1'b0, 1'b0, '0);
      cyc(1'b1, 8'h56, 1'b0, 1'b0, '0);
      drain(20);
      check_eq("t4_done_cnt", done_cnt - d0, 1);
      check_eq("t4_busy_end", sts_busy, AUTO);

      // 5: reset in the middle of a capture
`ifdef TRACE_FRAMER_AUTOREARM_EN
      do_reset();
`endif
      dout_ready = 1'b0;
      arm(16'd6);
      cyc(1'b1, 8'h80, 1'b1, 1'b0, '0);
      cyc(1'b1, 8'h81, 1'b0, 1'b0, '0);
      check_eq("t5_buffered", dout_valid, 1);
      do_reset();
      check_all_zero();
      dout_ready = 1'b1;
      idle(2);
      check_eq("t5_fifo_empty", dout_valid, 0);
      d0 = done_cnt;
      arm(16'd2);
      push(1'b0, 8'h90);
      cyc(1'b1, 8'h90, 1'b1, 1'b0, '0);
      push(1'b1, 8'h91);
      cyc(1'b1, 8'h91, 1'b0, 1'b0, '0);
      drain(20);
      check_eq("t5_done_cnt", done_cnt - d0, 1);
      check_eq("t5_busy_end", sts_busy, AUTO);

`ifdef TRACE_FRAMER_AUTOREARM_EN
      // 6: automatic re-arm, two frames of 2
      do_reset();
      d0 = done_cnt;
      arm(16'd2);
      for (int i = 0; i < 18; i++) begin
         d = 8'h60 + 8'(i);
         if (d == 8'h60 || d == 8'h70) push(1'b0, d);
         if (d == 8'h61 || d == 8'h71) push(1'b1, d);
         cyc(1'b1, d, (d == 8'h60) || (d == 8'h70), 1'b0, '0);
         check_eq("t6_busy", sts_busy, 1);
      end
      drain(20);
      check_eq("t6_done_cnt", done_cnt - d0, 2);
      check_eq("t6_state", dbg_state, ST_ARMED);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_trace_framer
